ext_col: RTL and testbench

EXT_COL -- requirements
Module: ExtCol

---
 rtl/ext_col.sv | 63 ++++++
 tb/tb_ext_col.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/ext_col.sv
// Column extractor: collects a byte window [i_r_start, i_end) from a row that
// arrives as 16-byte beats and presents it as one 32-byte column on row completion.
module ext_col (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_en,
  input  logic [4:0]   i_r_size,
  input  logic [127:0] i_r_data,
  input  logic [3:0]   i_r_start,
  input  logic [6:0]   i_end,
  output logic         o_en,
  output logic [255:0] o_col_data
);

  logic [4:0]   beat_cnt;
  logic [4:0]   eff_size;
  logic         last_beat;
  logic [255:0] acc;
  logic [255:0] acc_next;

  assign eff_size  = (i_r_size == 5'd0) ? 5'd1 : i_r_size;
  // >= rather than == so an out-of-contract size change mid-row still closes the row.
  assign last_beat = ({1'b0, beat_cnt} + 6'd1) >= {1'b0, eff_size};

  // Walk the column side: accumulator byte k comes from row byte i_r_start+k,
  // which lives in beat (i_r_start+k)/16 at lane (i_r_start+k)%16. Since
  // i_r_start+k <= 46, only beats 0..2 can ever contribute.
  // NOTE: every always_comb output gets a full default first so no latch is inferred.
  always_comb begin
    acc_next = acc;
    for (int k = 0; k < 32; k++) begin
      logic [5:0] pos;
      pos = 6'(i_r_start) + 6'(k);
      if ((beat_cnt == {3'b000, pos[5:4]}) && ({1'b0, pos} < i_end)) begin
        acc_next[8*k +: 8] = i_r_data[{pos[3:0], 3'b000} +: 8];
      end
    end
  end

  // NOTE: state uses non-blocking assignments so all flops update together on the edge.
  // NOTE: the accumulator is reset, not left undefined: unwritten column bytes must read 0.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      beat_cnt   <= '0;
      acc        <= '0;
      o_en       <= 1'b0;
      o_col_data <= '0;
    end else begin
      o_en <= i_en && last_beat;
      if (i_en) begin
        if (last_beat) begin
          o_col_data <= acc_next;
          acc        <= '0;
          beat_cnt   <= '0;
        end else begin
          acc        <= acc_next;
          beat_cnt   <= beat_cnt + 5'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ext_col.sv
// Directed self-checking bench for ext_col: reset, single/multi-beat rows,
// gaps, empty and truncated columns, back-to-back rows and mid-row reset.
module tb_ext_col;

  logic         i_clk;
  logic         i_rst_n;
  logic         i_en;
  logic [4:0]   i_r_size;
  logic [127:0] i_r_data;
  logic [3:0]   i_r_start;
  logic [6:0]   i_end;
  logic         o_en;
  logic [255:0] o_col_data;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [127:0] BEAT_X = 128'hffeeddccbbaa99887766554433221100;
  localparam logic [127:0] BEAT_A = 128'h0f0e0d0c0b0a09080706050403020100;
  localparam logic [127:0] BEAT_B = 128'h1f1e1d1c1b1a19181716151413121110;
  localparam logic [127:0] BEAT_C = 128'h2f2e2d2c2b2a29282726252423222120;

  ext_col dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_en       (i_en),
    .i_r_size   (i_r_size),
    .i_r_data   (i_r_data),
    .i_r_start  (i_r_start),
    .i_end      (i_end),
    .o_en       (o_en),
    .o_col_data (o_col_data)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one beat for exactly one rising edge; returns at the following falling edge.
  task automatic beat(input logic [127:0] d);
    @(negedge i_clk);
    i_en     = 1'b1;
    i_r_data = d;
    @(negedge i_clk);
    i_en     = 1'b0;
  endtask

  task automatic row_cfg(input logic [4:0] sz, input logic [3:0] st, input logic [6:0] en);
    i_r_size  = sz;
    i_r_start = st;
    i_end     = en;
  endtask

  initial begin
    i_rst_n   = 1'b0;
    i_en      = 1'b0;
    i_r_data  = '0;
    row_cfg(5'd1, 4'd0, 7'd16);

    // Reset held for 10 cycles
    for (int i = 0; i < 10; i++) begin
      @(negedge i_clk);
      check("rst_o_en", {255'd0, o_en}, 256'd0);
      check("rst_col", o_col_data, 256'd0);
    end
    i_rst_n = 1'b1;

    // Single full beat
    row_cfg(5'd1, 4'd0, 7'd16);
    beat(BEAT_X);
    check("full_o_en", {255'd0, o_en}, 256'd1);
    check("full_col", o_col_data, {128'h0, BEAT_X});
    for (int i = 0; i < 100; i++) begin
      @(negedge i_clk);
      check("idle_o_en", {255'd0, o_en}, 256'd0);
    end
    check("idle_hold", o_col_data, {128'h0, BEAT_X});

    // Window inside one beat
    row_cfg(5'd1, 4'd4, 7'd9);
    beat(BEAT_X);
    check("win_o_en", {255'd0, o_en}, 256'd1);
    check("win_col", o_col_data, 256'h8877665544);

    // Two beats with a 3-cycle gap, window straddling the beat boundary
    row_cfg(5'd2, 4'd8, 7'd24);
    beat(BEAT_A);
    check("gap_a_o_en", {255'd0, o_en}, 256'd0);
    for (int i = 0; i < 2; i++) begin
      @(negedge i_clk);
      check("gap_o_en", {255'd0, o_en}, 256'd0);
    end
    beat(BEAT_B);
    check("gap_b_o_en", {255'd0, o_en}, 256'd1);
    check("gap_col", o_col_data, {128'h0, 64'h1716151413121110, 64'h0f0e0d0c0b0a0908});
    @(negedge i_clk);
    check("gap_pulse_end", {255'd0, o_en}, 256'd0);

    // Empty column (end == start)
    row_cfg(5'd1, 4'd5, 7'd5);
    beat(BEAT_X);
    check("empty_o_en", {255'd0, o_en}, 256'd1);
    check("empty_col", o_col_data, 256'd0);

    // Size 0 behaves as size 1; end before start is also empty
    row_cfg(5'd0, 4'd9, 7'd3);
    beat(BEAT_X);
    check("size0_o_en", {255'd0, o_en}, 256'd1);
    check("size0_col", o_col_data, 256'd0);

    // Three beats, column truncated to 32 bytes, end past the row length
    row_cfg(5'd3, 4'd3, 7'd100);
    beat(BEAT_A);
    check("trunc_a_o_en", {255'd0, o_en}, 256'd0);
    beat(BEAT_B);
    check("trunc_b_o_en", {255'd0, o_en}, 256'd0);
    beat(BEAT_C);
    check("trunc_o_en", {255'd0, o_en}, 256'd1);
    check("trunc_col", o_col_data,
          256'h2221201f1e1d1c1b1a191817161514131211100f0e0d0c0b0a09080706050403);

    // Back-to-back single-beat rows with no bubble
    @(negedge i_clk);
    row_cfg(5'd1, 4'd0, 7'd16);
    i_en     = 1'b1;
    i_r_data = BEAT_A;
    @(negedge i_clk);
    check("b2b_1_o_en", {255'd0, o_en}, 256'd1);
    check("b2b_1_col", o_col_data, {128'h0, BEAT_A});
    row_cfg(5'd1, 4'd2, 7'd5);
    i_r_data = BEAT_X;
    @(negedge i_clk);
    i_en = 1'b0;
    check("b2b_2_o_en", {255'd0, o_en}, 256'd1);
    check("b2b_2_col", o_col_data, 256'h443322);

    // Mid-row reset discards the partial row
    row_cfg(5'd2, 4'd0, 7'd32);
    beat(BEAT_C);
    check("mid_o_en", {255'd0, o_en}, 256'd0);
    #2;
    i_rst_n = 1'b0;
    #1;
    check("mid_rst_o_en", {255'd0, o_en}, 256'd0);
    check("mid_rst_col", o_col_data, 256'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    beat(BEAT_A);
    check("post_a_o_en", {255'd0, o_en}, 256'd0);
    beat(BEAT_B);
    check("post_b_o_en", {255'd0, o_en}, 256'd1);
    check("post_col", o_col_data, {BEAT_B, BEAT_A});
    @(negedge i_clk);
    check("post_pulse_end", {255'd0, o_en}, 256'd0);
    check("post_hold", o_col_data, {BEAT_B, BEAT_A});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
